// File: rtl/snake_score_keeper.sv
// ============================================================================
//  Module      : snake_score_keeper
//  Description : Snake game score and phase tracker. Counts food events into a
//                saturating 7-bit score and owns the idle/play/over/win phase.
//                Optional best-score register enabled by macro HIGH_SCORE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_score_keeper #(
    parameter int MAX_POINTS      = 30,
    parameter int POINTS_PER_FOOD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       eat,
    input  logic       collide,
    output logic [6:0] points,
    output logic [6:0] best,
    output logic       playing,
    output logic       game_over,
    output logic       win
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_PLAY = 2'd1;
    localparam logic [1:0] c_S_OVER = 2'd2;
    localparam logic [1:0] c_S_WIN  = 2'd3;

    localparam logic [7:0] c_MAX8  = 8'(MAX_POINTS);
    localparam logic [6:0] c_MAX7  = 7'(MAX_POINTS);
    localparam logic [7:0] c_STEP8 = 8'(POINTS_PER_FOOD);

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [6:0] r_points;
    logic [6:0] w_points_next;
    logic       r_eat_q;
    logic       w_eat_rise;
    logic [7:0] w_sum;
    logic [6:0] w_sat;

    assign w_eat_rise = eat & ~r_eat_q;

    // Sum is one bit wider than the score so saturation can never see a wrap.
    assign w_sum = {1'b0, r_points} + c_STEP8;
    assign w_sat = (w_sum >= c_MAX8) ? c_MAX7 : w_sum[6:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_S_IDLE;
            r_points <= 7'd0;
            r_eat_q  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_points <= w_points_next;
            r_eat_q  <= eat;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_points_next = r_points;
        case (r_state)
            c_S_PLAY: begin
                // A collision wins over a food event arriving in the same cycle.
                if (collide) begin
                    w_state_next = c_S_OVER;
                end else if (w_eat_rise) begin
                    w_points_next = w_sat;
                    if (w_sat == c_MAX7) begin
                        w_state_next = c_S_WIN;
                    end
                end
            end
            c_S_IDLE,
            c_S_OVER,
            c_S_WIN: begin
                if (start) begin
                    w_state_next  = c_S_PLAY;
                    w_points_next = 7'd0;
                end
            end
            default: begin
                w_state_next  = c_S_IDLE;
                w_points_next = 7'd0;
            end
        endcase
    end

    assign points    = r_points;
    assign playing   = (r_state == c_S_PLAY);
    assign game_over = (r_state == c_S_OVER);
    assign win       = (r_state == c_S_WIN);

`ifdef HIGH_SCORE_EN
    logic [6:0] r_best;
    logic       w_game_end;

    // Leaving PLAY always means entering OVER or WIN; the score taken then is final.
    assign w_game_end = (r_state == c_S_PLAY) && (w_state_next != c_S_PLAY);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_best <= 7'd0;
        end else if (w_game_end && (w_points_next > r_best)) begin
            r_best <= w_points_next;
        end
    end

    assign best = r_best;
`else
    assign best = 7'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_snake_score_keeper.sv
// ============================================================================
//  Module      : tb_snake_score_keeper
//  Description : Self-checking bench for snake_score_keeper: directed game
//                scenarios followed by random play against a phase/score model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snake_score_keeper;

    localparam int MAX_POINTS      = 30;
    localparam int POINTS_PER_FOOD = 1;

    localparam int PH_IDLE = 0;
    localparam int PH_PLAY = 1;
    localparam int PH_OVER = 2;
    localparam int PH_WIN  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       eat = 1'b0;
    logic       collide = 1'b0;
    logic [6:0] points;
    logic [6:0] best;
    logic       playing;
    logic       game_over;
    logic       win;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state
    int m_phase    = PH_IDLE;
    int m_points   = 0;
    int m_best     = 0;
    bit m_prev_eat = 1'b0;

    snake_score_keeper #(
        .MAX_POINTS     (MAX_POINTS),
        .POINTS_PER_FOOD(POINTS_PER_FOOD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .eat      (eat),
        .collide  (collide),
        .points   (points),
        .best     (best),
        .playing  (playing),
        .game_over(game_over),
        .win      (win)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_vec++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_edge(input bit s, input bit e, input bit c, input bit r);
        bit food;
        if (r) begin
            m_phase    = PH_IDLE;
            m_points   = 0;
            m_best     = 0;
            m_prev_eat = 1'b0;
            return;
        end
        food       = e && !m_prev_eat;
        m_prev_eat = e;
        if (m_phase == PH_PLAY) begin
            if (c) begin
                m_phase = PH_OVER;
                if (m_points > m_best) m_best = m_points;
            end else if (food) begin
                m_points = m_points + POINTS_PER_FOOD;
                if (m_points >= MAX_POINTS) begin
                    m_points = MAX_POINTS;
                    m_phase  = PH_WIN;
                    m_best   = MAX_POINTS;
                end
            end
        end else if (s) begin
            m_phase  = PH_PLAY;
            m_points = 0;
        end
    endtask

    task automatic compare_all(input string where);
        int exp_best;
`ifdef HIGH_SCORE_EN
        exp_best = m_best;
`else
        exp_best = 0;
`endif
        check({where, ".points"},    int'(points),    m_points);
        check({where, ".best"},      int'(best),      exp_best);
        check({where, ".playing"},   int'(playing),   int'(m_phase == PH_PLAY));
        check({where, ".game_over"}, int'(game_over), int'(m_phase == PH_OVER));
        check({where, ".win"},       int'(win),       int'(m_phase == PH_WIN));
    endtask

    // One clock: drive inputs away from the edge, advance model at the edge, check after it.
    task automatic step(input string where, input bit s, input bit e, input bit c, input bit r);
        start   = s;
        eat     = e;
        collide = c;
        rst     = r;
        @(posedge clk);
        model_edge(s, e, c, r);
        #1;
        compare_all(where);
    endtask

    task automatic food_pulse(input string where);
        step(where, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) step(where, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset for two cycles, then release
        #1;
        step("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        step("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        step("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_points", int'(points), 0);

        // Start a game and score three single foods
        step("start", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) food_pulse("pulse");
        check("three_pulses", int'(points), 3);

        // Held eat counts once
        for (int i = 0; i < 10; i++) step("held", 1'b0, 1'b1, 1'b0, 1'b0);
        step("held_release", 1'b0, 1'b0, 1'b0, 1'b0);
        check("held_once", int'(points), 4);

        // Reach 5, then food and collision in the same cycle
        food_pulse("to_five");
        step("eat_collide", 1'b0, 1'b1, 1'b1, 1'b0);
        check("collide_points", int'(points), 5);
        check("collide_over", int'(game_over), 1);
        step("over_hold", 1'b0, 1'b0, 1'b0, 1'b0);

        // Restart from OVER, score 2, collide: best must not drop
        step("restart", 1'b1, 1'b0, 1'b0, 1'b0);
        check("restart_points", int'(points), 0);
        food_pulse("second_game");
        food_pulse("second_game");
        step("second_collide", 1'b0, 1'b0, 1'b1, 1'b0);
        step("second_over", 1'b0, 1'b0, 1'b0, 1'b0);

        // Full game to the win threshold, then extra foods
        step("win_start", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < MAX_POINTS; i++) food_pulse("to_win");
        check("win_points", int'(points), MAX_POINTS);
        check("win_flag", int'(win), 1);
        for (int i = 0; i < 3; i++) food_pulse("after_win");

        // Reset in the middle of a game at 12
        step("mid_start", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) food_pulse("to_twelve");
        check("twelve", int'(points), 12);
        step("mid_reset", 1'b0, 1'b0, 1'b0, 1'b1);
        step("post_reset", 1'b0, 1'b1, 1'b0, 1'b0);

        // Random play against the model
        for (int i = 0; i < 3000; i++) begin
            bit rs, rr, re, rc;
            rr = ($urandom_range(0, 299) == 0);
            rs = ($urandom_range(0, 11) == 0);
            rc = ($urandom_range(0, 59) == 0);
            re = ($urandom_range(0, 1) == 0);
            step("random", rs, re, rc, rr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
